// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - predictor counter table port owner: init sweep, update FIFO, read/write arbitration
module bp_update_scheduler #(
  parameter int IndexBits   = 10,
  parameter int CtrBits     = 2,
  parameter int FifoDepth   = 4,
  parameter int StarveLimit = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_bp_i,
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic [IndexBits-1:0] upd_index_i,
  input  logic [CtrBits-1:0]   upd_ctr_i,
  input  logic                 upd_taken_i,
  input  logic                 rd_req_i,
  input  logic [IndexBits-1:0] rd_index_i,
  output logic                 rd_gnt_o,
  output logic                 tbl_req_o,
  output logic                 tbl_we_o,
  output logic [IndexBits-1:0] tbl_addr_o,
  output logic [CtrBits-1:0]   tbl_wdata_o,
  output logic                 init_busy_o
);

  localparam int PtrBits    = $clog2(FifoDepth);
  localparam int StarveBits = $clog2(StarveLimit + 1);
  localparam logic [CtrBits-1:0]    InitVal   = CtrBits'((1 << (CtrBits - 1)) - 1);
  localparam logic [CtrBits-1:0]    CtrMax    = '1;
  localparam logic [IndexBits-1:0]  LastIdx   = '1;
  localparam logic [PtrBits:0]      FullCount = (PtrBits + 1)'(FifoDepth);
  localparam logic [StarveBits-1:0] StarveMax = StarveBits'(StarveLimit);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state, state_nxt;
  logic [IndexBits-1:0]   sweep_idx;
  logic [IndexBits-1:0]   fifo_index [FifoDepth];
  logic [CtrBits-1:0]     fifo_ctr   [FifoDepth];
  logic                   fifo_taken [FifoDepth];
  logic [PtrBits-1:0]     wr_ptr, rd_ptr;
  logic [PtrBits:0]       count;
  logic [StarveBits-1:0]  starve_cnt;
  logic                   fifo_full, fifo_nonempty, force_wr, push, pop;

  function automatic logic [CtrBits-1:0] next_ctr(input logic [CtrBits-1:0] ctr,
                                                   input logic taken);
    if (taken) return (ctr == CtrMax) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  assign fifo_full     = (count == FullCount);
  assign fifo_nonempty = (count != '0);
  assign force_wr      = fifo_nonempty && (starve_cnt == StarveMax);
  // An update arriving with a flush is dropped along with the queue contents.
  assign push          = upd_valid_i && upd_ready_o && !flush_bp_i;

  always_comb begin
    state_nxt   = state;
    rd_gnt_o    = 1'b0;
    upd_ready_o = 1'b0;
    tbl_req_o   = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = '0;
    tbl_wdata_o = InitVal;
    init_busy_o = 1'b0;
    pop         = 1'b0;
    case (state)
      S_INIT: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = sweep_idx;
        init_busy_o = 1'b1;
        if (sweep_idx == LastIdx) state_nxt = S_RUN;
      end
      S_RUN: begin
        upd_ready_o = !fifo_full;
        if (rd_req_i && !force_wr) begin
          rd_gnt_o   = 1'b1;
          tbl_req_o  = 1'b1;
          tbl_addr_o = rd_index_i;
        end else if (fifo_nonempty) begin
          tbl_req_o   = 1'b1;
          tbl_we_o    = 1'b1;
          tbl_addr_o  = fifo_index[rd_ptr];
          tbl_wdata_o = next_ctr(fifo_ctr[rd_ptr], fifo_taken[rd_ptr]);
          pop         = 1'b1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
    if (flush_bp_i) state_nxt = S_INIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_nxt;
      if (flush_bp_i)           sweep_idx <= '0;
      else if (state == S_INIT) sweep_idx <= sweep_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_bp_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_index[wr_ptr] <= upd_index_i;
      fifo_ctr[wr_ptr]   <= upd_ctr_i;
      fifo_taken[wr_ptr] <= upd_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (flush_bp_i || !fifo_nonempty || pop) begin
      starve_cnt <= '0;
    end else if (rd_gnt_o && starve_cnt != StarveMax) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
